vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller.
- Generates pixel coordinates, the active-video flag, and horizontal and vertical sync for any mode, with selectable sync polarity.
- Adds a pixel-clock enable, line-start and frame-start strobes, and a delay line that aligns sync and blanking with a downstream pixel pipeline such as the Sobel datapath.
- Sits between the system clock and the VGA pins and frame-buffer read logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, h_synq active level (0 = active-low)
- VS_POL, 0, v_synq active level (0 = active-low)
- CNT_W, 11, coordinate counter width; must satisfy 2^CNT_W >= max(H_TOTAL, V_TOTAL)
- PIPE_DLY, 2, pix_en ticks of delay on the d_* outputs; 0 means d_* equal the undelayed outputs

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- pix_en  in  1  pixel tick; the timing advances only on clk edges where pix_en=1
- pixel_x  out  CNT_W  current horizontal position, 0..H_TOTAL-1
- pixel_y  out  CNT_W  current vertical position, 0..V_TOTAL-1
- videoon  out  1  high when pixel_x<H_ACTIVE and pixel_y<V_ACTIVE
- h_synq  out  1  horizontal sync, level per HS_POL
- v_synq  out  1  vertical sync, level per VS_POL
- line_start  out  1  high while pixel_x==0
- frame_start  out  1  high while pixel_x==0 and pixel_y==0
- d_videoon, d_h_synq, d_v_synq  out  1 each  videoon/h_synq/v_synq delayed by PIPE_DLY ticks

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Clock and reset: single clk; reset sampled only on clk rising edge when rst_n=0; reset takes priority over pix_en.
- Reset values of all outputs:
  - pixel_x=0, pixel_y=0
  - videoon=0, line_start=0, frame_start=0
  - h_synq=~HS_POL, v_synq=~VS_POL
  - every delay-line stage and d_* output at its inactive value (videoon 0, sync inactive level)
- Output registers: all outputs are registered and load only on clk edges with pix_en=1. When pix_en=0, every output and internal state holds.
- Internal state: an internal next-position counter (nx, ny) resets to (0,0).
- On each pix_en edge:
  - outputs load the decode of (nx, ny);
  - nx advances; at nx==H_TOTAL-1, nx wraps to 0 and ny advances;
  - at (H_TOTAL-1, V_TOTAL-1), the position wraps to (0,0).
- First tick after reset: the first pix_en after rst_n deasserts presents (0,0) with videoon=1, line_start=1, frame_start=1. Latency from that pix_en edge to valid outputs is 1 clk.
- Decode, all ranges half-open:
  - h_synq is active when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC;
  - v_synq is active when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (the whole line, not pixel-aligned);
  - output level = active ? POL : ~POL.
- Strobes: line_start and frame_start are one tick wide, i.e. asserted for the entire span until the next pix_en edge.
- Delay line: a PIPE_DLY-deep shift register per signal (videoon, h_synq, v_synq), advancing only on pix_en. Pixel coordinates are not delayed.
- Reset mid-frame: on the next edge with rst_n=0, all state returns to reset values regardless of position or pix_en. The next frame starts cleanly from (0,0) on the first pix_en after release; no partial sync pulse is carried over.
- Simultaneous events:
  - line wrap and frame wrap on the same tick: pixel_x=0, pixel_y=0, both strobes high;
  - rst_n=0 and pix_en=1 together: reset wins.
- Arithmetic: all compare constants are derived from the parameters at elaboration and are CNT_W wide; no runtime arithmetic beyond the two incrementers.

Test Plan:
- Reset, then release with pix_en=1 every cycle: during reset outputs are 0/0/videoon=0/h_synq=1/v_synq=1. The first edge after release gives (0,0), videoon=1, frame_start=1; the next edge gives (1,0) with strobes 0.
- Default mode, pix_en=1 continuously:
  - videoon falls at x=640;
  - h_synq is low exactly for x=656..751 (96 ticks), else high;
  - x=799 is followed by x=0, y+1, line_start=1;
  - v_synq is low for y=490..491 across full lines.
- Frame wrap: (799,524) is followed by (0,0) with frame_start=1. Exactly 420000 pix_en ticks separate consecutive frame_start pulses.
- pix_en toggling 1,0,1,0: outputs change only on pix_en edges and hold otherwise; frame period becomes 840000 clk cycles.
- HS_POL=1, VS_POL=1, PIPE_DLY=3: h_synq is high for x=656..751. d_h_synq and d_videoon equal h_synq and videoon from 3 ticks earlier; after reset, d_* stay inactive for the first 3 ticks.
- Reset asserted at (300,200) with pix_en=1: the next edge restores all reset values. After release, the first tick gives (0,0) with frame_start=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// Produces the pixel position, the active-video flag, horizontal/vertical
// sync with selectable polarity, line/frame start strobes, and copies of
// videoon/h_synq/v_synq delayed by PIPE_DLY pixel ticks. The copies keep sync
// and blanking aligned with a downstream pixel pipeline.
// Ports:
//   clk, rst_n       system clock, synchronous active-low reset
//   pix_en           pixel tick; all state advances only when high
//   pixel_x/pixel_y  current position (CNT_W bits each)
//   videoon          inside the visible area
//   h_synq/v_synq    sync outputs, active level HS_POL/VS_POL
//   line_start       high while pixel_x == 0
//   frame_start      high while pixel_x == 0 and pixel_y == 0
//   d_videoon, d_h_synq, d_v_synq  PIPE_DLY-tick delayed copies
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = 11,
  parameter int PIPE_DLY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             videoon,
  output logic             h_synq,
  output logic             v_synq,
  output logic             line_start,
  output logic             frame_start,
  output logic             d_videoon,
  output logic             d_h_synq,
  output logic             d_v_synq
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON  = (HS_POL != 0);
  localparam logic HS_OFF = ~HS_ON;
  localparam logic VS_ON  = (VS_POL != 0);
  localparam logic VS_OFF = ~VS_ON;

  // nx/ny is the position that the next pix_en tick presents on the outputs.
  logic [CNT_W-1:0] nx_q, nx_d, ny_q, ny_d;
  logic [CNT_W-1:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic videoon_q, videoon_d, h_synq_q, h_synq_d, v_synq_q, v_synq_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;

  always_comb begin
    nx_d          = nx_q;
    ny_d          = ny_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    videoon_d     = videoon_q;
    h_synq_d      = h_synq_q;
    v_synq_d      = v_synq_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (pix_en) begin
      pixel_x_d     = nx_q;
      pixel_y_d     = ny_q;
      videoon_d     = (nx_q < H_VIS) && (ny_q < V_VIS);
      h_synq_d      = ((nx_q >= HS_BEG) && (nx_q < HS_END)) ? HS_ON : HS_OFF;
      v_synq_d      = ((ny_q >= VS_BEG) && (ny_q < VS_END)) ? VS_ON : VS_OFF;
      line_start_d  = (nx_q == '0);
      frame_start_d = (nx_q == '0) && (ny_q == '0);
      if (nx_q == H_LAST) begin
        nx_d = '0;
        ny_d = (ny_q == V_LAST) ? '0 : ny_q + ONE;
      end else begin
        nx_d = nx_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nx_q          <= '0;
      ny_q          <= '0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      videoon_q     <= 1'b0;
      h_synq_q      <= HS_OFF;
      v_synq_q      <= VS_OFF;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      nx_q          <= nx_d;
      ny_q          <= ny_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      videoon_q     <= videoon_d;
      h_synq_q      <= h_synq_d;
      v_synq_q      <= v_synq_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign videoon     = videoon_q;
  assign h_synq      = h_synq_q;
  assign v_synq      = v_synq_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

  // Delay line: stage 0 captures the registered output before it updates,
  // so the last stage shows the value from PIPE_DLY ticks earlier.
  if (PIPE_DLY == 0) begin : g_no_dly
    assign d_videoon = videoon_q;
    assign d_h_synq  = h_synq_q;
    assign d_v_synq  = v_synq_q;
  end else begin : g_dly
    logic [PIPE_DLY-1:0] dv_q, dv_d, dh_q, dh_d, dvs_q, dvs_d;

    always_comb begin
      dv_d  = dv_q;
      dh_d  = dh_q;
      dvs_d = dvs_q;
      if (pix_en) begin
        dv_d  = (dv_q << 1)  | PIPE_DLY'(videoon_q);
        dh_d  = (dh_q << 1)  | PIPE_DLY'(h_synq_q);
        dvs_d = (dvs_q << 1) | PIPE_DLY'(v_synq_q);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dv_q  <= '0;
        dh_q  <= {PIPE_DLY{HS_OFF}};
        dvs_q <= {PIPE_DLY{VS_OFF}};
      end else begin
        dv_q  <= dv_d;
        dh_q  <= dh_d;
        dvs_q <= dvs_d;
      end
    end

    assign d_videoon = dv_q[PIPE_DLY-1];
    assign d_h_synq  = dh_q[PIPE_DLY-1];
    assign d_v_synq  = dvs_q[PIPE_DLY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one instance in the default 640x480 mode
// (PIPE_DLY=2) and one in a small 16x10 mode with active-high syncs and
// PIPE_DLY=3, both sharing clk, rst_n and pix_en.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, pix_en;

  logic [10:0] a_x, a_y;
  logic a_vid, a_hs, a_vs, a_ls, a_fs, a_dvid, a_dhs, a_dvs;
  logic [4:0] b_x, b_y;
  logic b_vid, b_hs, b_vs, b_ls, b_fs, b_dvid, b_dhs, b_dvs;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .pixel_x(a_x), .pixel_y(a_y), .videoon(a_vid), .h_synq(a_hs), .v_synq(a_vs),
    .line_start(a_ls), .frame_start(a_fs),
    .d_videoon(a_dvid), .d_h_synq(a_dhs), .d_v_synq(a_dvs)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .CNT_W(5), .PIPE_DLY(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .pixel_x(b_x), .pixel_y(b_y), .videoon(b_vid), .h_synq(b_hs), .v_synq(b_vs),
    .line_start(b_ls), .frame_start(b_fs),
    .d_videoon(b_dvid), .d_h_synq(b_dhs), .d_v_synq(b_dvs)
  );

  int tests = 0;
  int fails = 0;
  int n = 0;  // pix_en ticks since reset release

  // Expected values for tick k (k <= 0 means still at reset value).
  // sm=0: default mode 800x525, syncs active-low at x 656..751, y 490..491.
  // sm=1: small mode 16x10, syncs active-high at x 10..12, y 7..8.
  function automatic int ex_x(input bit sm, input int k);
    if (k <= 0) return 0;
    return (k - 1) % (sm ? 16 : 800);
  endfunction

  function automatic int ex_y(input bit sm, input int k);
    if (k <= 0) return 0;
    return ((k - 1) / (sm ? 16 : 800)) % (sm ? 10 : 525);
  endfunction

  function automatic logic ex_vid(input bit sm, input int k);
    if (k <= 0) return 1'b0;
    return (ex_x(sm, k) < (sm ? 8 : 640)) && (ex_y(sm, k) < (sm ? 6 : 480));
  endfunction

  function automatic logic ex_hs(input bit sm, input int k);
    int x;
    if (k <= 0) return !sm;
    x = ex_x(sm, k);
    if (sm) return (x >= 10 && x <= 12);
    return !(x >= 656 && x <= 751);
  endfunction

  function automatic logic ex_vs(input bit sm, input int k);
    int y;
    if (k <= 0) return !sm;
    y = ex_y(sm, k);
    if (sm) return (y >= 7 && y <= 8);
    return !(y >= 490 && y <= 491);
  endfunction

  task automatic step(input logic en);
    pix_en = en;
    @(posedge clk);
    #1;
    if (!rst_n) n = 0;
    else if (en) n++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1);
    tests++; if (a_x !== 11'd0 || a_y !== 11'd0) begin fails++;
      $display("FAIL reset_pos got (%0d,%0d) exp (0,0)", a_x, a_y); end
    tests++; if ({a_vid, a_hs, a_vs, a_ls, a_fs} !== 5'b01100) begin fails++;
      $display("FAIL reset_a_flags got %b exp 01100", {a_vid, a_hs, a_vs, a_ls, a_fs}); end
    tests++; if ({a_dvid, a_dhs, a_dvs} !== 3'b011) begin fails++;
      $display("FAIL reset_a_delayed got %b exp 011", {a_dvid, a_dhs, a_dvs}); end
    tests++; if ({b_vid, b_hs, b_vs, b_dvid, b_dhs, b_dvs} !== 6'b000000) begin fails++;
      $display("FAIL reset_b_flags got %b exp 000000", {b_vid, b_hs, b_vs, b_dvid, b_dhs, b_dvs}); end
  endtask

  task automatic test_first_ticks;
    rst_n = 1'b1;
    step(1'b1);
    tests++; if (a_x !== 11'd0 || a_y !== 11'd0 || {a_vid, a_ls, a_fs, a_hs} !== 4'b1111) begin fails++;
      $display("FAIL first_tick got (%0d,%0d) vid/ls/fs/hs=%b exp (0,0) 1111", a_x, a_y, {a_vid, a_ls, a_fs, a_hs}); end
    tests++; if (a_dvid !== 1'b0) begin fails++;
      $display("FAIL first_tick_dvid got %b exp 0", a_dvid); end
    step(1'b1);
    tests++; if (a_x !== 11'd1 || a_y !== 11'd0 || {a_ls, a_fs} !== 2'b00) begin fails++;
      $display("FAIL second_tick got (%0d,%0d) ls/fs=%b exp (1,0) 00", a_x, a_y, {a_ls, a_fs}); end
  endtask

  task automatic test_default_line;
    int hs_low = 0;
    for (int i = 0; i < 1700; i++) begin
      step(1'b1);
      if (a_y == 11'd0 && a_hs == 1'b0) hs_low++;
      tests++; if (a_x !== 11'(ex_x(0, n)) || a_y !== 11'(ex_y(0, n))) begin fails++;
        $display("FAIL line_pos n=%0d got (%0d,%0d) exp (%0d,%0d)", n, a_x, a_y, ex_x(0, n), ex_y(0, n)); end
      tests++; if ({a_vid, a_hs, a_vs} !== {ex_vid(0, n), ex_hs(0, n), ex_vs(0, n)}) begin fails++;
        $display("FAIL line_flags n=%0d got %b exp %b", n, {a_vid, a_hs, a_vs}, {ex_vid(0, n), ex_hs(0, n), ex_vs(0, n)}); end
      tests++; if (a_ls !== (ex_x(0, n) == 0) || a_fs !== (ex_x(0, n) == 0 && ex_y(0, n) == 0)) begin fails++;
        $display("FAIL line_strobes n=%0d got ls=%b fs=%b", n, a_ls, a_fs); end
      tests++; if ({a_dvid, a_dhs, a_dvs} !== {ex_vid(0, n-2), ex_hs(0, n-2), ex_vs(0, n-2)}) begin fails++;
        $display("FAIL line_delayed n=%0d got %b exp %b", n, {a_dvid, a_dhs, a_dvs}, {ex_vid(0, n-2), ex_hs(0, n-2), ex_vs(0, n-2)}); end
      if (n == 641) begin
        tests++; if (a_x !== 11'd640 || a_vid !== 1'b0) begin fails++;
          $display("FAIL vid_edge got x=%0d vid=%b exp x=640 vid=0", a_x, a_vid); end
      end
      if (n == 801) begin
        tests++; if (a_x !== 11'd0 || a_y !== 11'd1 || a_ls !== 1'b1 || a_fs !== 1'b0) begin fails++;
          $display("FAIL line_wrap got (%0d,%0d) ls=%b fs=%b exp (0,1) 1 0", a_x, a_y, a_ls, a_fs); end
      end
    end
    tests++; if (hs_low != 96) begin fails++;
      $display("FAIL hsync_width got %0d exp 96", hs_low); end
  endtask

  task automatic test_small_mode;
    int last_fs = -1;
    int periods = 0;
    for (int i = 0; i < 400; i++) begin
      step(1'b1);
      tests++; if (b_x !== 5'(ex_x(1, n)) || b_y !== 5'(ex_y(1, n))) begin fails++;
        $display("FAIL small_pos n=%0d got (%0d,%0d) exp (%0d,%0d)", n, b_x, b_y, ex_x(1, n), ex_y(1, n)); end
      tests++; if ({b_vid, b_hs, b_vs} !== {ex_vid(1, n), ex_hs(1, n), ex_vs(1, n)}) begin fails++;
        $display("FAIL small_flags n=%0d got %b exp %b", n, {b_vid, b_hs, b_vs}, {ex_vid(1, n), ex_hs(1, n), ex_vs(1, n)}); end
      tests++; if ({b_dvid, b_dhs, b_dvs} !== {ex_vid(1, n-3), ex_hs(1, n-3), ex_vs(1, n-3)}) begin fails++;
        $display("FAIL small_delayed n=%0d got %b exp %b", n, {b_dvid, b_dhs, b_dvs}, {ex_vid(1, n-3), ex_hs(1, n-3), ex_vs(1, n-3)}); end
      if (b_fs === 1'b1) begin
        tests++; if (b_x !== 5'd0 || b_y !== 5'd0 || b_ls !== 1'b1) begin fails++;
          $display("FAIL frame_wrap got (%0d,%0d) ls=%b exp (0,0) 1", b_x, b_y, b_ls); end
        if (last_fs >= 0) begin
          periods++;
          tests++; if (n - last_fs != 160) begin fails++;
            $display("FAIL frame_period got %0d exp 160", n - last_fs); end
        end
        last_fs = n;
      end
    end
    tests++; if (periods < 2) begin fails++;
      $display("FAIL frame_count got %0d exp >=2", periods); end
  endtask

  task automatic test_pix_en_hold;
    logic [10:0] px;
    int rise = 0, first = -1, cyc = 0;
    logic prev_fs;
    for (int i = 0; i < 60; i++) begin
      px = a_x;
      step((i % 2) == 0);
      tests++; if (a_x !== 11'(ex_x(0, n)) || b_x !== 5'(ex_x(1, n)) || b_dvid !== ex_vid(1, n-3)) begin fails++;
        $display("FAIL toggle n=%0d got a_x=%0d b_x=%0d b_dvid=%b", n, a_x, b_x, b_dvid); end
      if ((i % 2) == 1) begin
        tests++; if (a_x !== px) begin fails++;
          $display("FAIL hold got %0d exp %0d", a_x, px); end
      end
    end
    prev_fs = b_fs;
    for (int i = 0; i < 1000 && rise < 2; i++) begin
      step((i % 2) == 0);
      cyc++;
      if (b_fs === 1'b1 && prev_fs === 1'b0) begin
        rise++;
        if (rise == 1) first = cyc;
        else begin
          tests++; if (cyc - first != 320) begin fails++;
            $display("FAIL toggle_period got %0d exp 320", cyc - first); end
        end
      end
      prev_fs = b_fs;
    end
    tests++; if (rise < 2) begin fails++;
      $display("FAIL toggle_timeout got %0d rises exp 2", rise); end
  endtask

  task automatic test_reset_mid;
    int guard = 0;
    while (a_x != 11'd300 && guard < 900) begin step(1'b1); guard++; end
    tests++; if (a_x !== 11'd300) begin fails++;
      $display("FAIL mid_reach got %0d exp 300", a_x); end
    rst_n = 1'b0;
    step(1'b1);
    tests++; if (a_x !== 11'd0 || a_y !== 11'd0 || {a_vid, a_hs, a_vs, a_ls, a_fs} !== 5'b01100) begin fails++;
      $display("FAIL mid_reset_a got (%0d,%0d) %b", a_x, a_y, {a_vid, a_hs, a_vs, a_ls, a_fs}); end
    tests++; if ({a_dvid, a_dhs, a_dvs, b_dvid, b_dhs, b_dvs, b_hs, b_vs} !== 8'b01100000) begin fails++;
      $display("FAIL mid_reset_delayed got %b exp 01100000", {a_dvid, a_dhs, a_dvs, b_dvid, b_dhs, b_dvs, b_hs, b_vs}); end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      tests++; if (a_x !== 11'(ex_x(0, n)) || a_fs !== (n == 1) || b_x !== 5'(ex_x(1, n)) || b_fs !== (n == 1)) begin fails++;
        $display("FAIL restart n=%0d got a=(%0d,fs=%b) b=(%0d,fs=%b)", n, a_x, a_fs, b_x, b_fs); end
      tests++; if ({b_dvid, b_dhs, b_dvs} !== {ex_vid(1, n-3), ex_hs(1, n-3), ex_vs(1, n-3)} || a_dvid !== ex_vid(0, n-2)) begin fails++;
        $display("FAIL restart_delayed n=%0d got b=%b a_dvid=%b", n, {b_dvid, b_dhs, b_dvs}, a_dvid); end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    pix_en = 1'b0;
    test_reset;
    test_first_ticks;
    test_default_line;
    test_small_mode;
    test_pix_en_hold;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
